systolic_feeder: RTL and testbench

Upstream sequencer for the `systolic` array. Accepts one tile (ARRAY_SIZE weight rows followed by ARRAY_SIZE unskewed activation vectors) over a valid/ready stream and buffers it. It then replays the tile into the array: a weight-load burst, a one-cycle gap, and diagonally skewed activations. Its outputs connect directly to the array's `load`, `weights` and `activations` inputs.

---
 rtl/systolic_feeder.sv | 102 ++++++++++
 tb/tb_systolic_feeder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers one tile (N weight rows, N activation vectors) from a valid/ready stream and replays it as weight load, one gap cycle, then skewed activations; SYSTOLIC_FEEDER_DRAIN_EN adds an N-cycle drain before done. Ports: clk, reset (sync, active-high), in_valid/in_ready/in_data (tile input), load/weights/activations (to array), busy, done.
module systolic_feeder #(
  parameter int ARRAY_SIZE = 2,
  parameter int DATA_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_data,
  output logic                             load,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] weights,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] activations,
  output logic                             busy,
  output logic                             done
);
  localparam int N  = ARRAY_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int BW = N * DW;
  localparam int CW = $clog2(2 * N) + 1;
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
  typedef enum logic [2:0] {COLLECT, WLOAD, GAP, STREAM, DRAIN, DONE} state_t;
`else
  typedef enum logic [2:0] {COLLECT, WLOAD, GAP, STREAM, DONE} state_t;
`endif
  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [BW-1:0]   w [N];
  logic [BW-1:0]   a [N];
  logic [BW-1:0]   w_n, a_n;
  assign in_ready = state == COLLECT;
  assign busy     = state != COLLECT;
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    case (state)
      COLLECT: begin
        state_n = in_valid && cnt == CW'(2 * N - 1) ? WLOAD : COLLECT;
        cnt_n   = !in_valid ? cnt : cnt == CW'(2 * N - 1) ? '0 : cnt + 1'b1;
      end
      WLOAD: if (cnt == CW'(N - 1)) begin
        state_n = GAP;
        cnt_n   = '0;
      end
      GAP: begin
        state_n = STREAM;
        cnt_n   = '0;
      end
      STREAM: if (cnt == CW'(2 * N - 2)) begin
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
        state_n = DRAIN;
`else
        state_n = DONE;
`endif
        cnt_n   = '0;
      end
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
      DRAIN: if (cnt == CW'(N - 1)) begin
        state_n = DONE;
        cnt_n   = '0;
      end
`endif
      default: begin
        state_n = COLLECT;
        cnt_n   = '0;
      end
    endcase
    // Outputs are registered, so they are decoded from the state being entered.
    w_n = '0;
    a_n = '0;
    for (int k = 0; k < N; k++)
      if (state_n == WLOAD && cnt_n == CW'(k)) w_n = w[k];
    // Lane i at stream step t carries row j = t - i, giving the diagonal skew.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (state_n == STREAM && cnt_n == CW'(i + j)) a_n[i*DW +: DW] = a[j][i*DW +: DW];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= COLLECT;
      cnt         <= '0;
      w           <= '{default: '0};
      a           <= '{default: '0};
      load        <= 1'b0;
      weights     <= '0;
      activations <= '0;
      done        <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (in_ready && in_valid)
        for (int k = 0; k < N; k++) begin
          if (cnt == CW'(k)) w[k] <= in_data;
          if (cnt == CW'(N + k)) a[k] <= in_data;
        end
      load        <= state_n == WLOAD;
      weights     <= w_n;
      activations <= a_n;
      done        <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: scoreboard bench for systolic_feeder replay sequencing, skew, reset and ignored input.
module tb_systolic_feeder;
  localparam int N  = 2;
  localparam int DW = 4;
  localparam int BW = N * DW;
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
  localparam int DRAIN_CYC = N;
`else
  localparam int DRAIN_CYC = 0;
`endif
  typedef struct packed {
    logic          load;
    logic [BW-1:0] w;
    logic [BW-1:0] a;
    logic          done;
  } exp_t;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          load;
  logic [BW-1:0] weights;
  logic [BW-1:0] activations;
  logic          busy;
  logic          done;
  exp_t          q[$];
  logic [BW-1:0] tile [2*N];
  int            checks = 0;
  int            failures = 0;
  always #5 clk = ~clk;
  systolic_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .load(load), .weights(weights), .activations(activations), .busy(busy), .done(done)
  );
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic push_expected();
    exp_t e;
    for (int j = 0; j < N; j++) begin
      e = '0;
      e.load = 1'b1;
      e.w = tile[j];
      q.push_back(e);
    end
    e = '0;
    q.push_back(e);
    for (int t = 0; t < 2 * N - 1; t++) begin
      e = '0;
      for (int i = 0; i < N; i++)
        if (t - i >= 0 && t - i < N) e.a[i*DW +: DW] = tile[N + t - i][i*DW +: DW];
      q.push_back(e);
    end
    for (int d = 0; d < DRAIN_CYC; d++) begin
      e = '0;
      q.push_back(e);
    end
    e = '0;
    e.done = 1'b1;
    q.push_back(e);
  endtask
  task automatic send_tile(input int gap, input bit hold_ff);
    for (int b = 0; b < 2 * N; b++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = tile[b];
      @(posedge clk);
      if (gap > 0 && b < 2 * N - 1) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data = BW'($urandom);
        repeat (gap - 1) @(negedge clk);
      end
    end
    push_expected();
    @(negedge clk);
    in_valid = hold_ff;
    in_data = hold_ff ? {BW{1'b1}} : BW'($urandom);
  endtask
  task automatic check_idle(input string name);
    checks++;
    if ({in_ready, busy, load, done, weights, activations} !== {1'b1, 1'b0, 1'b0, 1'b0, BW'(0), BW'(0)}) begin
      failures++;
      $display("FAIL %s got rdy=%b busy=%b load=%b done=%b w=%h a=%h exp rdy=1 busy=0 load=0 done=0 w=0 a=0",
               name, in_ready, busy, load, done, weights, activations);
    end
  endtask
  task automatic check_replay(input string name, input int abort_at);
    exp_t e;
    int   k;
    for (k = 0; q.size() > 0; k++) begin
      if (k == abort_at) break;
      if (k > 0) @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({load, weights, activations, done, busy, in_ready} !== {e.load, e.w, e.a, e.done, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL %s[%0d] got load=%b w=%h a=%h done=%b busy=%b rdy=%b exp load=%b w=%h a=%h done=%b busy=1 rdy=0",
                 name, k, load, weights, activations, done, busy, in_ready, e.load, e.w, e.a, e.done);
      end
    end
    if (q.size() > 0) q.delete();
    else begin
      in_valid = 1'b0;
      @(negedge clk);
      check_idle({name, "_rearm"});
    end
  endtask
  task automatic load_nominal();
    tile[0] = 8'h43;
    tile[1] = 8'h21;
    tile[2] = 8'h21;
    tile[3] = 8'h43;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_idle("reset");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_idle("idle");
    end
  endtask
  task automatic test_nominal();
    load_nominal();
    send_tile(0, 1'b0);
    checks++;
    if ({load, weights} !== {1'b1, 8'h43}) begin
      failures++;
      $display("FAIL nominal_first_row got load=%b w=%h exp load=1 w=43", load, weights);
    end
    check_replay("nominal", -1);
  endtask
  task automatic test_gapped();
    load_nominal();
    send_tile(3, 1'b0);
    check_replay("gapped", -1);
  endtask
  task automatic test_ignored_input();
    tile[0] = 8'h5a;
    tile[1] = 8'h3c;
    tile[2] = 8'h96;
    tile[3] = 8'he1;
    send_tile(0, 1'b1);
    check_replay("ignored", -1);
    load_nominal();
    send_tile(0, 1'b0);
    check_replay("after_ignored", -1);
  endtask
  task automatic test_mid_reset();
    load_nominal();
    send_tile(0, 1'b0);
    check_replay("pre_reset", N + 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("mid_reset");
    for (int c = 0; c < 4 * N + 4; c++) begin
      @(negedge clk);
      check_idle("post_reset_quiet");
    end
    tile[0] = 8'h78;
    tile[1] = 8'h9a;
    tile[2] = 8'hbc;
    tile[3] = 8'hde;
    send_tile(0, 1'b0);
    check_replay("fresh_tile", -1);
  endtask
  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      for (int b = 0; b < 2 * N; b++) tile[b] = BW'($urandom);
      send_tile(r, 1'b0);
      check_replay("random", -1);
    end
  endtask
  initial begin
    test_reset();
    test_nominal();
    test_gapped();
    test_ignored_input();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
